aes_key_expand: RTL and testbench

- Iterative AES-128 key schedule. Produces the 11 round keys (rounds 0..10), one per clock, from a 128-bit cipher key.
- Sits directly upstream of the round datapath. Each round key feeds AddRoundKey, whose result is the state consumed by subBytes.
- Contains its own 4-lane S-box for SubWord, so it does not share the subBytes instance.

---
 rtl/aes_key_expand.sv | 126 ++++++++++++
 tb/tb_aes_key_expand.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 on consecutive cycles
// from a 128-bit cipher key. SubWord has its own 4-lane S-box.
module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);

  typedef enum logic {IDLE, EXPAND} state_t;

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte idx sits at bit (255-idx)*8+7, i.e. {~idx, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] idx);
    return SBOX[{~idx, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {k[23:0], k[31:24]};
    t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = k[127:96] ^ t;
    n1  = k[95:64]  ^ n0;
    n2  = k[63:32]  ^ n1;
    n3  = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   rk_out_d;
  logic [3:0]     rk_round_d;
  logic           rk_valid_d, busy_d, done_d;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rk_out   <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rk_out   <= rk_out_d;
      rk_round <= rk_round_d;
      rk_valid <= rk_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic: load on start, then step one round per edge.
  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out;
    rk_round_d = rk_round;
    rk_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_out_d   = key_in;
          rk_round_d = '0;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = EXPAND;
        end
      end
      EXPAND: begin
        if (rk_round == 4'd10) begin
          state_d = IDLE;
        end else begin
          rk_out_d   = next_key(rk_out, rcon(rk_round + 4'd1));
          rk_round_d = rk_round + 4'd1;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = (rk_round == 4'd9);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed-vector bench for aes_key_expand using FIPS-197 key schedules.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;

  int unsigned  n_vec = 0;
  int unsigned  n_bad = 0;

  logic [127:0] fips_keys [0:10];
  logic [127:0] exp_keys  [0:10];
  logic [10:0]  exp_known;
  logic [127:0] got_keys  [0:10];
  logic [127:0] run1_keys [0:10];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PLAINTEXT = 128'h3243f6a8885a308d313198a2e0370734;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge right after start was driven. Follows one full run,
  // optionally pulsing start/zero key at two rounds, or keeping start held.
  task automatic collect(input string tag, input int pulse_a, input int pulse_b, input bit hold);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rk_valid && waited < 4);
    check({tag, "_latency"}, 128'(waited), 128'd1);
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) @(negedge clk);
      check($sformatf("%s_valid%0d", tag, r), 128'(rk_valid), 128'd1);
      check($sformatf("%s_round%0d", tag, r), 128'(rk_round), 128'(r));
      check($sformatf("%s_done%0d", tag, r), 128'(done), 128'(r == 10));
      check($sformatf("%s_busy%0d", tag, r), 128'(busy), 128'd1);
      got_keys[r] = rk_out;
      if (exp_known[r]) check($sformatf("%s_key%0d", tag, r), rk_out, exp_keys[r]);
      if (r == pulse_a || r == pulse_b) begin
        start  = 1'b1;
        key_in = '0;
      end else if (!hold) begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_idle_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_idle_busy"}, 128'(busy), 128'd0);
    check({tag, "_idle_done"}, 128'(done), 128'd0);
    if (!hold) start = 1'b0;
  endtask

  task automatic set_fips_expect();
    for (int r = 0; r <= 10; r++) exp_keys[r] = fips_keys[r];
    exp_known = '1;
  endtask

  initial begin
    fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_round", 128'(rk_round), 128'd0);
    check("rst_out", rk_out, 128'd0);
    rst_n = 1'b1;

    // 1: FIPS-197 key, started on the same negedge reset is released
    set_fips_expect();
    start  = 1'b1;
    key_in = FIPS_KEY;
    collect("fips", -1, -1, 1'b0);

    // 3: AddRoundKey of the FIPS plaintext with round 0
    check("ark_round0", got_keys[0] ^ PLAINTEXT, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // 2: all-zero key
    @(negedge clk);
    exp_known     = '0;
    exp_known[1]  = 1'b1;
    exp_known[10] = 1'b1;
    exp_keys[1]   = 128'h62636363626363636263636362636363;
    exp_keys[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    start  = 1'b1;
    key_in = '0;
    collect("zero", -1, -1, 1'b0);

    // 4: start pulses with zero key at rounds 3 and 10 must be ignored
    @(negedge clk);
    set_fips_expect();
    start  = 1'b1;
    key_in = FIPS_KEY;
    collect("busy_start", 3, 10, 1'b0);
    @(negedge clk);
    check("no_restart_valid", 128'(rk_valid), 128'd0);
    check("no_restart_busy", 128'(busy), 128'd0);

    // 5: asynchronous reset in the middle of round 5
    start  = 1'b1;
    key_in = FIPS_KEY;
    begin
      int waited = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        waited++;
      end while (!(rk_valid && rk_round == 4'd5) && waited < 12);
      check("areset_reach_r5", 128'(rk_round), 128'd5);
    end
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", 128'(busy), 128'd0);
    check("areset_valid", 128'(rk_valid), 128'd0);
    check("areset_done", 128'(done), 128'd0);
    check("areset_round", 128'(rk_round), 128'd0);
    check("areset_out", rk_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_known     = '0;
    exp_known[0]  = 1'b1;
    exp_known[1]  = 1'b1;
    exp_known[10] = 1'b1;
    exp_keys[0]   = '0;
    exp_keys[1]   = 128'h62636363626363636263636362636363;
    exp_keys[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    start  = 1'b1;
    key_in = '0;
    collect("post_reset", -1, -1, 1'b0);

    // 6: start held high for 30 cycles -> back-to-back runs, one idle cycle apart
    @(negedge clk);
    set_fips_expect();
    start  = 1'b1;
    key_in = FIPS_KEY;
    collect("hold_run1", -1, -1, 1'b1);
    for (int r = 0; r <= 10; r++) run1_keys[r] = got_keys[r];
    collect("hold_run2", -1, -1, 1'b1);
    for (int r = 0; r <= 10; r++)
      check($sformatf("hold_same%0d", r), got_keys[r], run1_keys[r]);
    repeat (5) @(negedge clk);
    start = 1'b0;
    begin
      int waited = 0;
      while (busy && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("hold_drain_busy", 128'(busy), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
